// File: rtl/bcd_pkg.sv
// Shared constants and types for the multiplexed four-digit BCD display.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_word_t;

endpackage

// File: rtl/bcd_seg7_dec.sv
// Combinational BCD-to-seven-segment decoder with a blank override.
// Non-decimal nibbles render as a dash.
module bcd_seg7_dec
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed four-digit display driver. New values are captured into a
// pending register and only committed at the frame boundary to avoid tearing.
module bcd_display_scan
  import bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        valid,
  input  logic        lz_blank,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned TickW = $clog2(SCAN_DIV);

  logic [TickW-1:0] tick_q, tick_d;
  logic [1:0]       idx_q, idx_d;
  bcd_word_t        disp_q, disp_d;
  bcd_word_t        pend_q, pend_d;
  logic             busy_q, busy_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_nxt;
  logic             step, commit, blank_nxt;
  logic [3:0]       digit_nxt;

  always_comb begin
    step   = (tick_q == TickW'(SCAN_DIV - 1));
    tick_d = step ? '0 : tick_q + TickW'(1);
    idx_d  = step ? idx_q + 2'd1 : idx_q;
    commit = step && (idx_q == 2'd3);

    disp_d = disp_q;
    pend_d = pend_q;
    busy_d = busy_q;
    if (commit && busy_q) begin
      disp_d = pend_q;
      busy_d = 1'b0;
    end
    // A strobe on the commit edge becomes the next pending value.
    if (valid) begin
      pend_d = bcd;
      busy_d = 1'b1;
    end

    // Decode from next-state values so seg matches the index it is shown with.
    digit_nxt = disp_d[idx_d];
    unique case (idx_d)
      2'd3:    blank_nxt = lz_blank && (disp_d[3] == 4'd0);
      2'd2:    blank_nxt = lz_blank && (disp_d[3] == 4'd0) && (disp_d[2] == 4'd0);
      2'd1:    blank_nxt = lz_blank && (disp_d[3] == 4'd0) && (disp_d[2] == 4'd0)
                           && (disp_d[1] == 4'd0);
      default: blank_nxt = 1'b0;
    endcase

    an_d        = 4'b1111;
    an_d[idx_d] = 1'b0;
  end

  bcd_seg7_dec u_dec (
    .digit_i (digit_nxt),
    .blank_i (blank_nxt),
    .seg_o   (seg_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
      disp_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      an_q   <= 4'b1110;
      seg_q  <= SEG_0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      if (step) begin
        an_q  <= an_d;
        seg_q <= seg_nxt;
      end
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with SCAN_DIV=4 (16-cycle frames).
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd;
  logic        valid;
  logic        lz_blank;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SD = 7'b0111111, SO = 7'b1111111;

  bcd_display_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd      (bcd),
    .valid    (valid),
    .lz_blank (lz_blank),
    .busy     (busy),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    bcd   = v;
    valid = 1'b1;
    tick_n(1);
    valid = 1'b0;
  endtask

  // Called at the start of a digit-0 slot; leaves at the start of the next one.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg = '{s0, s1, s2, s3};
    for (int d = 0; d < 4; d++) begin
      exp_an    = 4'b1111;
      exp_an[d] = 1'b0;
      check_eq($sformatf("%s_an%0d", tag, d), 32'(an), 32'(exp_an));
      check_eq($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(exp_seg[d]));
      tick_n(4);
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    bcd      = 16'h0;
    lz_blank = 1'b1;
    tick_n(2);
    check_eq("rst_an", 32'(an), 32'h0e);
    check_eq("rst_seg", 32'(seg), 32'(S0));
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Idle scan, with and without blanking.
    check_frame("idle_lz1", S0, SO, SO, SO);
    lz_blank = 1'b0;
    check_frame("idle_lz0", S0, S0, S0, S0);
    lz_blank = 1'b1;

    // Mid-frame capture of 0907.
    tick_n(5);
    pulse(16'h0907);
    check_eq("c1_busy_mid", 32'(busy), 32'h1);
    check_eq("c1_seg_old", 32'(seg), 32'(SO));
    tick_n(9);
    check_eq("c1_busy_d3", 32'(busy), 32'h1);
    tick_n(1);
    check_eq("c1_busy_clr", 32'(busy), 32'h0);
    check_frame("c1", S7, S0, S9, SO);

    // Latest wins: 1234 overwritten by 5678 within the same frame.
    tick_n(2);
    pulse(16'h1234);
    tick_n(1);
    pulse(16'h5678);
    tick_n(11);
    check_frame("c2a", S8, S7, S6, S5);
    check_frame("c2b", S8, S7, S6, S5);
    check_eq("c2_busy", 32'(busy), 32'h0);

    // Strobe on the commit edge while 0001 is pending.
    tick_n(2);
    pulse(16'h0001);
    tick_n(12);
    pulse(16'h00AF);
    check_eq("c3_busy_hold", 32'(busy), 32'h1);
    check_frame("c3a", S1, SO, SO, SO);
    check_eq("c3_busy_clr", 32'(busy), 32'h0);
    check_frame("c3b", SD, SD, SO, SO);

    // Reset mid-frame discards pending 9999.
    tick_n(2);
    pulse(16'h9999);
    tick_n(6);
    check_eq("c4_busy_pre", 32'(busy), 32'h1);
    check_eq("c4_an_pre", 32'(an), 32'h0b);
    rst = 1'b1;
    tick_n(1);
    check_eq("c4_rst_an", 32'(an), 32'h0e);
    check_eq("c4_rst_seg", 32'(seg), 32'(S0));
    check_eq("c4_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    check_frame("c4a", S0, SO, SO, SO);
    check_frame("c4b", S0, SO, SO, SO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
